mips_store_buffer: RTL and testbench

//  Posted-write buffer between the single-cycle core's data port and the data memory.

---
 rtl/mips_store_buffer.sv | 244 ++++++++++++++++++++++++
 tb/tb_mips_store_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_store_buffer.sv
// -----------------------------------------------------------------------------
// mips_store_buffer
// Posted-write buffer between a single-cycle MIPS core's data port and data
// memory. Core stores are queued in a small in-order FIFO and drained to memory
// over a req/ack handshake, so the core keeps one-cycle store timing. Loads
// forward from the youngest matching buffered store, else read memory.
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_cpu_a          core data byte address (word granularity used)
//   i_cpu_we         core store strobe
//   i_cpu_re         core load strobe
//   i_cpu_wd         core store data
//   o_cpu_rd         load data to core (combinational)
//   o_stall          core must hold pc and retry the store (combinational)
//   o_mem_ra         memory read address (= i_cpu_a)
//   i_mem_rdata      memory read data (combinational from o_mem_ra)
//   o_mem_req        write request (registered)
//   o_mem_a          write address, word aligned (registered)
//   o_mem_wd         write data (registered)
//   i_mem_ack        memory accepted the write, sampled while o_mem_req=1
//   o_count          occupied entries
//   o_empty          no entries occupied
// -----------------------------------------------------------------------------
module mips_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ADDR_W-1:0]          i_cpu_a,
    input  logic                       i_cpu_we,
    input  logic                       i_cpu_re,
    input  logic [DATA_W-1:0]          i_cpu_wd,
    output logic [DATA_W-1:0]          o_cpu_rd,
    output logic                       o_stall,
    output logic [ADDR_W-1:0]          o_mem_ra,
    input  logic [DATA_W-1:0]          i_mem_rdata,
    output logic                       o_mem_req,
    output logic [ADDR_W-1:0]          o_mem_a,
    output logic [DATA_W-1:0]          o_mem_wd,
    input  logic                       i_mem_ack,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [WA_W-1:0]     r_addr [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;

    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_a;
    logic [DATA_W-1:0]   r_mem_wd;
    logic                w_req_next;
    logic [ADDR_W-1:0]   w_a_next;
    logic [DATA_W-1:0]   w_wd_next;

    logic [WA_W-1:0]     w_cpu_wa;
    logic                w_merge_hit;
    logic [PTR_W-1:0]    w_merge_idx;
    logic                w_fwd_hit;
    logic [DATA_W-1:0]   w_fwd_data;
    logic                w_full;
    logic                w_stall;
    logic                w_push;
    logic                w_pop;
    logic                w_wr_en;
    logic [PTR_W-1:0]    w_wr_idx;
    logic [PTR_W-1:0]    w_ld_idx;
    logic [WA_W-1:0]     w_ld_wa;
    logic [DATA_W-1:0]   w_ld_data;

    assign w_cpu_wa = i_cpu_a[ADDR_W-1:2];

    // Scan entries oldest to youngest so the last hit is the youngest match.
    // The head is excluded from merging while it is under request (data frozen),
    // but still forwards to loads.
    always_comb begin : p_match
        logic [PTR_W-1:0] v_idx;
        v_idx       = '0;
        w_merge_hit = 1'b0;
        w_merge_idx = '0;
        w_fwd_hit   = 1'b0;
        w_fwd_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_addr[v_idx] == w_cpu_wa)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[v_idx];
                if ((k != 0) || (r_state == ST_IDLE)) begin
                    w_merge_hit = 1'b1;
                    w_merge_idx = v_idx;
                end else begin
                    w_merge_hit = w_merge_hit;
                end
            end else begin
                w_fwd_hit = w_fwd_hit;
            end
        end
    end

    // Enqueue / pop control. A same-cycle pop does not relieve a full stall.
    always_comb begin
        w_full       = (r_count == CNT_FULL);
        w_stall      = i_cpu_we & w_full & ~w_merge_hit;
        w_push       = i_cpu_we & ~w_full & ~w_merge_hit;
        w_pop        = (r_state == ST_REQ) & r_mem_req & i_mem_ack;
        w_wr_en      = i_cpu_we & ~w_stall;
        w_wr_idx     = w_merge_hit ? w_merge_idx : r_wr_ptr;
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Next head for the write port, bypassing a store landing in that slot
    // this very cycle so the request never carries stale data.
    always_comb begin
        w_ld_idx  = (r_state == ST_REQ) ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
        if (w_wr_en && (w_wr_idx == w_ld_idx)) begin
            w_ld_wa   = w_cpu_wa;
            w_ld_data = i_cpu_wd;
        end else begin
            w_ld_wa   = r_addr[w_ld_idx];
            w_ld_data = r_data[w_ld_idx];
        end
    end

    // Drain FSM next-state and next write-port values.
    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_mem_req;
        w_a_next     = r_mem_a;
        w_wd_next    = r_mem_wd;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = ST_REQ;
                    w_req_next   = 1'b1;
                    w_a_next     = {w_ld_wa, 2'b00};
                    w_wd_next    = w_ld_data;
                end else begin
                    w_req_next   = 1'b0;
                end
            end
            ST_REQ: begin
                if (w_pop) begin
                    if (w_count_next != '0) begin
                        w_state_next = ST_REQ;
                        w_req_next   = 1'b1;
                        w_a_next     = {w_ld_wa, 2'b00};
                        w_wd_next    = w_ld_data;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_req_next   = 1'b0;
                    end
                end else begin
                    w_req_next   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    // FSM state and registered write-port outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_mem_a   <= '0;
            r_mem_wd  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_mem_req <= w_req_next;
            r_mem_a   <= w_a_next;
            r_mem_wd  <= w_wd_next;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // Entry storage: push writes address and data, merge rewrites data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_addr[w_wr_idx] <= w_cpu_wa;
            r_data[w_wr_idx] <= i_cpu_wd;
        end else begin
            r_addr[w_wr_idx] <= r_addr[w_wr_idx];
            r_data[w_wr_idx] <= r_data[w_wr_idx];
        end
    end

    assign o_cpu_rd  = (i_cpu_re && w_fwd_hit) ? w_fwd_data : i_mem_rdata;
    assign o_stall   = w_stall;
    assign o_mem_ra  = i_cpu_a;
    assign o_mem_req = r_mem_req;
    assign o_mem_a   = r_mem_a;
    assign o_mem_wd  = r_mem_wd;
    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);

endmodule

// File: tb/tb_mips_store_buffer.sv
module tb_mips_store_buffer;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_a;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        stall;
    logic [31:0] mem_ra;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_ack;
    logic [2:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] got_log[$];
    logic [63:0] exp_log[$];

    mips_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cpu_a     (cpu_a),
        .i_cpu_we    (cpu_we),
        .i_cpu_re    (cpu_re),
        .i_cpu_wd    (cpu_wd),
        .o_cpu_rd    (cpu_rd),
        .o_stall     (stall),
        .o_mem_ra    (mem_ra),
        .i_mem_rdata (mem_rdata),
        .o_mem_req   (mem_req),
        .o_mem_a     (mem_a),
        .o_mem_wd    (mem_wd),
        .i_mem_ack   (mem_ack),
        .o_count     (count),
        .o_empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted memory write in issue order.
    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack) got_log.push_back({mem_a, mem_wd});
    end

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        ack;
        logic [31:0] e_rd;
        logic        e_stall;
        logic        e_req;
        logic        chk_mem;
        logic [31:0] e_a;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] wd, input logic ack);
        cpu_we  = we;
        cpu_re  = re;
        cpu_a   = a;
        cpu_wd  = wd;
        mem_ack = ack;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] wd);
        drive(1'b1, 1'b0, a, wd, 1'b0);
        tick();
    endtask

    // Ack every request until n writes have been seen (bounded), then compare
    // the issued writes against the expected program order.
    task automatic drain(input string name, input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int c = 0; c < 30 && got_log.size() < n; c++) tick();
        mem_ack = 1'b0;
        #1;
        chk({name, " idle req"}, {31'h0, mem_req}, 32'h0);
        chk({name, " idle count"}, {29'h0, count}, 32'h0);
        chk({name, " nwrites"}, got_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            if (i < got_log.size()) begin
                chk($sformatf("%s wr%0d addr", name, i), got_log[i][63:32], exp_log[i][63:32]);
                chk($sformatf("%s wr%0d data", name, i), got_log[i][31:0], exp_log[i][31:0]);
            end
        end
        got_log.delete();
        exp_log.delete();
    endtask

    initial begin
        // we re a wd rdata ack | rd stall req chk a wd cnt
        vecs[0]  = '{1'b1,1'b0,32'h10,32'hAAAA,32'h0,   1'b0, 32'h0,   1'b0,1'b0,1'b1,32'h0, 32'h0,   3'd0};
        vecs[1]  = '{1'b0,1'b0,32'h0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0,1'b0,1'b1,32'h0, 32'h0,   3'd1};
        vecs[2]  = '{1'b0,1'b1,32'h12,32'h0,   32'h1,   1'b0, 32'hAAAA,1'b0,1'b1,1'b1,32'h10,32'hAAAA,3'd1};
        vecs[3]  = '{1'b0,1'b0,32'h0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0,1'b1,1'b1,32'h10,32'hAAAA,3'd1};
        vecs[4]  = '{1'b0,1'b0,32'h0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0,1'b1,1'b1,32'h10,32'hAAAA,3'd1};
        vecs[5]  = '{1'b0,1'b0,32'h0, 32'h0,   32'h0,   1'b1, 32'h0,   1'b0,1'b1,1'b1,32'h10,32'hAAAA,3'd1};
        vecs[6]  = '{1'b0,1'b1,32'h10,32'h0,   32'h5555,1'b0, 32'h5555,1'b0,1'b0,1'b0,32'h0, 32'h0,   3'd0};
        vecs[7]  = '{1'b0,1'b1,32'h40,32'h0,   32'h1234,1'b0, 32'h1234,1'b0,1'b0,1'b0,32'h0, 32'h0,   3'd0};
        vecs[8]  = '{1'b1,1'b0,32'h43,32'h7,   32'h1234,1'b0, 32'h1234,1'b0,1'b0,1'b0,32'h0, 32'h0,   3'd0};
        vecs[9]  = '{1'b0,1'b1,32'h42,32'h0,   32'h1234,1'b0, 32'h7,   1'b0,1'b0,1'b0,32'h0, 32'h0,   3'd1};
        vecs[10] = '{1'b0,1'b1,32'h40,32'h0,   32'h1234,1'b1, 32'h7,   1'b0,1'b1,1'b1,32'h40,32'h7,   3'd1};
        vecs[11] = '{1'b0,1'b1,32'h40,32'h0,   32'h99,  1'b0, 32'h99,  1'b0,1'b0,1'b0,32'h0, 32'h0,   3'd0};
        vecs[12] = '{1'b1,1'b1,32'h50,32'hBB,  32'h77,  1'b0, 32'h77,  1'b0,1'b0,1'b0,32'h0, 32'h0,   3'd0};
        vecs[13] = '{1'b0,1'b1,32'h50,32'h0,   32'h77,  1'b0, 32'hBB,  1'b0,1'b0,1'b0,32'h0, 32'h0,   3'd1};
        vecs[14] = '{1'b0,1'b0,32'h0, 32'h0,   32'h0,   1'b1, 32'h0,   1'b0,1'b1,1'b1,32'h50,32'hBB,  3'd1};
        vecs[15] = '{1'b0,1'b0,32'h0, 32'h0,   32'h0,   1'b0, 32'h0,   1'b0,1'b0,1'b0,32'h0, 32'h0,   3'd0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mem_rdata = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("reset req",   {31'h0, mem_req}, 32'h0);
        chk("reset count", {29'h0, count},   32'h0);
        chk("reset empty", {31'h0, empty},   32'h1);
        chk("reset mem_a", mem_a,            32'h0);

        // Single store handshake, forwarding and load/store same cycle.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd, vecs[i].ack);
            mem_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d cpu_rd", i), cpu_rd, vecs[i].e_rd);
            chk($sformatf("v%0d stall", i), {31'h0, stall}, {31'h0, vecs[i].e_stall});
            chk($sformatf("v%0d req", i), {31'h0, mem_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d count", i), {29'h0, count}, {29'h0, vecs[i].e_cnt});
            chk($sformatf("v%0d empty", i), {31'h0, empty}, {31'h0, (vecs[i].e_cnt == 3'd0)});
            chk($sformatf("v%0d mem_ra", i), mem_ra, vecs[i].a);
            if (vecs[i].chk_mem) begin
                chk($sformatf("v%0d mem_a", i), mem_a, vecs[i].e_a);
                chk($sformatf("v%0d mem_wd", i), mem_wd, vecs[i].e_wd);
            end
            @(posedge clk);
            #1;
        end
        mem_rdata = 32'h0;
        exp_log.push_back({32'h10, 32'hAAAA});
        exp_log.push_back({32'h40, 32'h7});
        exp_log.push_back({32'h50, 32'hBB});
        drain("table", 3);

        // Reset in the middle of a request.
        sw(32'h0, 32'h1);
        sw(32'h4, 32'h2);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rst pre req",   {31'h0, mem_req}, 32'h1);
        chk("rst pre count", {29'h0, count},   32'h2);
        rst_n = 1'b0;
        #1;
        chk("rst async req", {31'h0, mem_req}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst post count", {29'h0, count},   32'h0);
        chk("rst post empty", {31'h0, empty},   32'h1);
        chk("rst post req",   {31'h0, mem_req}, 32'h0);
        chk("rst post mem_a", mem_a,            32'h0);
        chk("rst post mem_wd", mem_wd,          32'h0);
        got_log.delete();

        // Full queue stalls until a pop has happened at an edge.
        sw(32'h0, 32'h10);
        sw(32'h4, 32'h11);
        sw(32'h8, 32'h12);
        sw(32'hC, 32'h13);
        drive(1'b1, 1'b0, 32'h20, 32'h14, 1'b0);
        #1;
        chk("full stall", {31'h0, stall}, 32'h1);
        chk("full count", {29'h0, count}, 32'h4);
        tick();
        chk("full stall hold", {31'h0, stall}, 32'h1);
        mem_ack = 1'b1;
        #1;
        chk("full stall w/ ack", {31'h0, stall}, 32'h1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("after pop stall", {31'h0, stall}, 32'h0);
        chk("after pop count", {29'h0, count}, 32'h3);
        chk("after pop mem_a", mem_a, 32'h4);
        tick();
        chk("enq count", {29'h0, count}, 32'h4);
        exp_log.push_back({32'h0, 32'h10});
        exp_log.push_back({32'h4, 32'h11});
        exp_log.push_back({32'h8, 32'h12});
        exp_log.push_back({32'hC, 32'h13});
        exp_log.push_back({32'h20, 32'h14});
        drain("order", 5);

        // Merge into a non-head entry while the head is frozen.
        sw(32'h8, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h8, 32'h2, 1'b0);
        #1;
        chk("m sw2 stall", {31'h0, stall}, 32'h0);
        tick();
        chk("m sw2 count", {29'h0, count}, 32'h2);
        sw(32'h8, 32'h3);
        drive(1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
        mem_rdata = 32'hDEAD;
        #1;
        chk("m count", {29'h0, count}, 32'h2);
        chk("m lw fwd", cpu_rd, 32'h3);
        chk("m head wd", mem_wd, 32'h1);
        mem_rdata = 32'h0;
        exp_log.push_back({32'h8, 32'h1});
        exp_log.push_back({32'h8, 32'h3});
        drain("merge", 2);

        // Full queue, store to a non-head address merges without stalling.
        sw(32'h0, 32'h20);
        sw(32'h4, 32'h21);
        sw(32'h8, 32'h22);
        sw(32'hC, 32'h23);
        drive(1'b1, 1'b0, 32'hC, 32'h55, 1'b0);
        #1;
        chk("fm stall", {31'h0, stall}, 32'h0);
        tick();
        chk("fm count", {29'h0, count}, 32'h4);
        drive(1'b1, 1'b0, 32'h0, 32'h66, 1'b0);
        #1;
        chk("fm head stall", {31'h0, stall}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        exp_log.push_back({32'h0, 32'h20});
        exp_log.push_back({32'h4, 32'h21});
        exp_log.push_back({32'h8, 32'h22});
        exp_log.push_back({32'hC, 32'h55});
        drain("fullmerge", 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
